// File: rtl/scc_wave_i2s.sv
// I2S serial output for the SCC mono wave: one 16-bit word per frame, sent on both channels.
// Bit and word clocks come from clk21m through an internal divider.
module scc_wave_i2s #(
  parameter int unsigned BCLK_DIV = 7
) (
  input  logic        clk21m,
  input  logic        reset,
  input  logic        enable,
  input  logic [14:0] wavl,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        sample_tick
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned BIT_W = 5;
  localparam int unsigned SMP_W = 16;
  localparam int unsigned FRM_W = 2 * SMP_W;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [FRM_W-1:0] shreg;

  logic             div_wrap_c;
  logic             fe_c;
  logic [BIT_W-1:0] k_c;
  logic [SMP_W-1:0] s_c;

  // A falling edge is the divider wrap while bclk is currently high.
  assign div_wrap_c = (div_cnt == DIV_LAST);
  assign fe_c       = div_wrap_c & i2s_bclk;
  assign k_c        = bit_cnt + BIT_W'(1);
  assign s_c        = enable ? {wavl, 1'b0} : '0;

  // Bit clock divider.
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_wrap_c) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Frame sequencing: everything advances on the bclk falling edge.
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '1;
      shreg       <= '0;
      i2s_sdata   <= 1'b0;
      i2s_lrclk   <= 1'b1;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= fe_c && (k_c == '0);
      if (fe_c) begin
        bit_cnt   <= k_c;
        i2s_sdata <= shreg[FRM_W-1];
        i2s_lrclk <= k_c[BIT_W-1];
        if (k_c == '0) begin
          shreg <= {s_c, s_c};
        end else begin
          shreg <= {shreg[FRM_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_scc_wave_i2s.sv
// Directed bench for scc_wave_i2s: decodes the I2S stream like a DAC and checks words and timing.
module tb_scc_wave_i2s;

  logic        clk21m = 1'b0;
  logic        reset;
  logic        enable;
  logic [14:0] wavl;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        sample_tick;

  int checks = 0;
  int errors = 0;

  scc_wave_i2s #(.BCLK_DIV(7)) dut (
    .clk21m      (clk21m),
    .reset       (reset),
    .enable      (enable),
    .wavl        (wavl),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .sample_tick (sample_tick)
  );

  always #5 clk21m = ~clk21m;

  // Monitor state: edge timing and an lrclk-aligned word decoder.
  int          cyc = 0;
  logic        prev_bclk = 1'b0, prev_lr = 1'b1, prev_sd = 1'b0;
  int          t_brise, t_bfall, t_lrrise, t_lrfall, t_tick;
  bit          h_brise, h_bfall, h_lrrise, h_lrfall, h_tick;
  int          bclk_hi_len = 0, bclk_lo_len = 0, lr_lo_len = 0, lr_hi_len = 0, tick_period = 0;
  int          align_err = 0, bclk_rises = 0, lr_changes = 0, sd_ones = 0;
  logic [15:0] rx = '0, last_left = '0, last_right = '0;

  always @(posedge clk21m) begin
    #1;
    cyc++;
    if (reset) begin
      prev_bclk = 1'b0; prev_lr = 1'b1; prev_sd = 1'b0; rx = '0;
      h_brise = 0; h_bfall = 0; h_lrrise = 0; h_lrfall = 0; h_tick = 0;
    end else begin
      automatic bit fe = prev_bclk && !i2s_bclk;
      automatic bit re = !prev_bclk && i2s_bclk;
      if (re) begin
        if (h_bfall) bclk_lo_len = cyc - t_bfall;
        t_brise = cyc; h_brise = 1; bclk_rises++;
      end
      if (fe) begin
        if (h_brise) bclk_hi_len = cyc - t_brise;
        t_bfall = cyc; h_bfall = 1;
        rx = {rx[14:0], i2s_sdata};
        if (i2s_lrclk != prev_lr) begin
          if (prev_lr) last_right = rx;
          else last_left = rx;
        end
      end
      if (i2s_lrclk != prev_lr) begin
        if (!fe) align_err++;
        lr_changes++;
        if (i2s_lrclk) begin
          if (h_lrfall) lr_lo_len = cyc - t_lrfall;
          t_lrrise = cyc; h_lrrise = 1;
        end else begin
          if (h_lrrise) lr_hi_len = cyc - t_lrrise;
          t_lrfall = cyc; h_lrfall = 1;
        end
      end
      if (i2s_sdata != prev_sd && !fe) align_err++;
      if (i2s_sdata) sd_ones++;
      if (sample_tick) begin
        if (!fe) align_err++;
        if (h_tick) tick_period = cyc - t_tick;
        t_tick = cyc; h_tick = 1;
      end
      prev_bclk = i2s_bclk; prev_lr = i2s_lrclk; prev_sd = i2s_sdata;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk21m);
      #2;
    end
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      step();
      if (sample_tick) seen = 1;
    end
    if (!seen) check("tick_timeout", 0, 1);
  endtask

  // Counts cycles from reset release to the first bclk rise and the first sample_tick.
  task automatic check_restart(input string tag);
    int first_rise, first_tick;
    first_rise = -1; first_tick = -1;
    for (int n = 1; n <= 40 && first_tick < 0; n++) begin
      step();
      if (i2s_bclk && first_rise < 0) first_rise = n;
      if (sample_tick) begin
        first_tick = n;
        check({tag, "_first_sdata"}, int'(i2s_sdata), 0);
      end
    end
    check({tag, "_first_bclk_rise"}, first_rise, 7);
    check({tag, "_first_tick"}, first_tick, 14);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bclk"},  int'(i2s_bclk), 0);
    check({tag, "_lrclk"}, int'(i2s_lrclk), 1);
    check({tag, "_sdata"}, int'(i2s_sdata), 0);
    check({tag, "_tick"},  int'(sample_tick), 0);
  endtask

  typedef struct {
    logic [14:0] wavl;
    logic        en;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{15'h1234, 1'b1, 16'h2468};
    vecs[1] = '{15'h4000, 1'b1, 16'h8000};
    vecs[2] = '{15'h3FFF, 1'b1, 16'h7FFE};
    vecs[3] = '{15'h0001, 1'b1, 16'h0002};
    vecs[4] = '{15'h7FFF, 1'b1, 16'hFFFE};
    vecs[5] = '{15'h5555, 1'b0, 16'h0000};
    vecs[6] = '{15'h5555, 1'b1, 16'hAAAA};
    vecs[7] = '{15'h0000, 1'b1, 16'h0000};

    reset = 1'b1; enable = 1'b1; wavl = '0;
    #12;
    check_reset_outputs("por");
    @(negedge clk21m);
    reset = 1'b0;
    check_restart("por");

    // Free run, then check clock shapes.
    for (int f = 0; f < 3; f++) wait_tick();
    check("bclk_high", bclk_hi_len, 7);
    check("bclk_low", bclk_lo_len, 7);
    check("lrclk_low", lr_lo_len, 224);
    check("lrclk_high", lr_hi_len, 224);
    check("tick_period", tick_period, 448);

    // Table: set inputs mid-frame, capture next frame, check it one frame later.
    for (int v = 0; v < 8; v++) begin
      wavl = vecs[v].wavl; enable = vecs[v].en;
      wait_tick();
      wait_tick();
      check($sformatf("vec%0d_left", v), int'(last_left), int'(vecs[v].exp));
      check($sformatf("vec%0d_right", v), int'(last_right), int'(vecs[v].exp));
    end

    // Mid-frame wavl change, then mid-frame enable drop.
    wavl = 15'h0001; enable = 1'b1;
    wait_tick();
    step(140);
    wavl = 15'h7FFF;
    wait_tick();
    check("midwavl_left", int'(last_left), 16'h0002);
    check("midwavl_right", int'(last_right), 16'h0002);
    step(100);
    enable = 1'b0;
    wait_tick();
    check("miden_left", int'(last_left), 16'hFFFE);
    check("miden_right", int'(last_right), 16'hFFFE);
    wait_tick();
    check("endrop_left", int'(last_left), 0);
    check("endrop_right", int'(last_right), 0);

    // Enable low for three frames: silent data, clocks keep running.
    wavl = 15'h5555; enable = 1'b0;
    wait_tick();
    sd_ones = 0; bclk_rises = 0; lr_changes = 0;
    step(3 * 448);
    check("disabled_sdata_ones", sd_ones, 0);
    check("disabled_bclk_rises", bclk_rises, 96);
    check("disabled_lr_changes", lr_changes, 6);
    enable = 1'b1; wavl = 15'h1234;

    // Asynchronous reset mid-frame, then a clean restart.
    step(200);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step(3);
    @(negedge clk21m);
    reset = 1'b0;
    check_restart("midrst");
    wait_tick();
    wait_tick();
    check("post_reset_left", int'(last_left), 16'h2468);
    check("post_reset_right", int'(last_right), 16'h2468);

    check("edge_alignment", align_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
